// File: rtl/rom16x8_pkg.sv
// rom16x8_pkg: shared constants, types and contents for the 16x8 squares lookup ROM.
//   ROM_DEPTH / ADDR_W / DATA_W : geometry of the table (fixed 16 x 8).
//   ROM_TABLE                   : constant contents, entry i = (i * i) mod 256.
//   rom_lookup()                : pure combinational read of ROM_TABLE.
package rom16x8_pkg;

    localparam int unsigned ROM_DEPTH = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 8;

    typedef logic [ADDR_W-1:0] rom_addr_t;
    typedef logic [DATA_W-1:0] rom_word_t;

    // Squares table, written out literally so the contents are visible at a glance.
    localparam rom_word_t ROM_TABLE [ROM_DEPTH] = '{
        8'h00, 8'h01, 8'h04, 8'h09, 8'h10, 8'h19, 8'h24, 8'h31,
        8'h40, 8'h51, 8'h64, 8'h79, 8'h90, 8'hA9, 8'hC4, 8'hE1
    };

    // An X address yields an X word in four-state simulation, since the index is unknown.
    function automatic rom_word_t rom_lookup(input rom_addr_t addr);
        return ROM_TABLE[addr];
    endfunction

endpackage

// File: rtl/rom16x8_table.sv
// rom16x8_table: purely combinational address -> word decode of the squares ROM.
//   addr : word address 0x0..0xF
//   word : table contents at addr (no registering here)
module rom16x8_table
    import rom16x8_pkg::*;
(
    input  logic [3:0] addr,
    output logic [7:0] word
);

    always_comb begin
        word = rom_lookup(addr);
    end

endmodule

// File: rtl/rom16x8.sv
// rom16x8: 16-word x 8-bit read-only lookup with a registered read port.
//   clk  : system clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset, forces data to RESET_VALUE
//   re   : read enable, sampled on the rising clk edge
//   addr : word address, sampled on the rising clk edge
//   data : registered read data, one cycle after a read; held while re is low
// ADDR_W and DATA_W are fixed at 4 and 8; other values are not supported.
module rom16x8 #(
    parameter int unsigned          ADDR_W      = 4,
    parameter int unsigned          DATA_W      = 8,
    parameter logic [DATA_W-1:0]    RESET_VALUE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    rom16x8_table u_table (
        .addr (addr),
        .word (word)
    );

    // Hold the previous word when re is low; addr is then irrelevant.
    always_comb begin
        data_d = data_q;
        if (re) begin
            data_d = word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // Output comes straight from the register: no combinational path from addr or re.
    assign data = data_q;

endmodule

// File: tb/tb_rom16x8.sv
// tb_rom16x8: self-checking bench for rom16x8. Expected words come from plain
// arithmetic (addr * addr mod 256), not from the RTL table.
module tb_rom16x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       re;
    logic [3:0] addr;
    logic [7:0] data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rom16x8 dut (
        .clk  (clk),
        .rst  (rst),
        .re   (re),
        .addr (addr),
        .data (data)
    );

    function automatic logic [7:0] square(input int unsigned a);
        return 8'((a * a) % 256);
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        re   = 1'b1;
        addr = 4'h5;
        #1;
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", data, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, data, 8'h00);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (data !== square(5)) begin
            errors++;
            $display("FAIL reset_first_read: got %h expected %h", data, square(5));
        end
    endtask

    task automatic test_read_disabled();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        re   = 1'b0;
        addr = 4'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data !== 8'h00) begin
                errors++;
                $display("FAIL read_disabled[%0d]: got %h expected %h", i, data, 8'h00);
            end
        end
    endtask

    task automatic test_sweep();
        re = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            checks++;
            if (data !== square(i)) begin
                errors++;
                $display("FAIL sweep[%0d]: got %h expected %h", i, data, square(i));
            end
        end
    endtask

    task automatic test_hold();
        re   = 1'b1;
        addr = 4'hA;
        tick();
        checks++;
        if (data !== 8'h64) begin
            errors++;
            $display("FAIL hold_load: got %h expected %h", data, 8'h64);
        end
        re   = 1'b0;
        addr = 4'hF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (data !== 8'h64) begin
                errors++;
                $display("FAIL hold_keep[%0d]: got %h expected %h", i, data, 8'h64);
            end
        end
        re = 1'b1;
        tick();
        checks++;
        if (data !== 8'hE1) begin
            errors++;
            $display("FAIL hold_resume: got %h expected %h", data, 8'hE1);
        end
    endtask

    task automatic test_async_reset();
        re = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = 4'(i);
            tick();
        end
        checks++;
        if (data !== 8'h31) begin
            errors++;
            $display("FAIL async_pre: got %h expected %h", data, 8'h31);
        end
        addr = 4'h8;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL async_clear: got %h expected %h", data, 8'h00);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL async_after_release: got %h expected %h", data, 8'h00);
        end
        tick();
        checks++;
        if (data !== 8'h40) begin
            errors++;
            $display("FAIL async_next_read: got %h expected %h", data, 8'h40);
        end
    endtask

    task automatic test_repeat();
        re   = 1'b1;
        addr = 4'h3;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (data !== 8'h09) begin
                errors++;
                $display("FAIL repeat[%0d]: got %h expected %h", i, data, 8'h09);
            end
            @(negedge clk);
            checks++;
            if (data !== 8'h09) begin
                errors++;
                $display("FAIL repeat_mid[%0d]: got %h expected %h", i, data, 8'h09);
            end
        end
    endtask

    // Random re/addr with occasional asynchronous reset pulses between edges.
    task automatic test_random();
        logic [7:0] expected;
        expected = 8'h09;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                #2 rst = 1'b1;
                #1;
                expected = 8'h00;
                checks++;
                if (data !== expected) begin
                    errors++;
                    $display("FAIL random_rst[%0d]: got %h expected %h", i, data, expected);
                end
                rst = 1'b0;
            end
            re   = 1'($urandom_range(0, 1));
            addr = 4'($urandom);
            tick();
            if (re) begin
                expected = square(addr);
            end
            checks++;
            if (data !== expected) begin
                errors++;
                $display("FAIL random[%0d]: re=%0b addr=%h got %h expected %h",
                         i, re, addr, data, expected);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_disabled();
        test_sweep();
        test_hold();
        test_async_reset();
        test_repeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
